// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard sequencer.
package hazard_pkg;

    localparam int unsigned INSTR_W   = 19;
    localparam int unsigned REG_W     = 3;
    localparam int unsigned SRC_A_LSB = 8;
    localparam int unsigned SRC_B_LSB = 5;
    localparam int unsigned DST_LSB   = 11;
    localparam int unsigned STALL_W   = 16;
    localparam int unsigned FCNT_W    = 2;

    // Encodings are visible on hz_state, so they are pinned explicitly.
    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StLdStall = 2'b01,
        StFlush   = 2'b10,
        StMemWait = 2'b11
    } hz_state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Extract a register-index field starting at lsb.
    function automatic logic [REG_W-1:0] instr_field(input logic [INSTR_W-1:0] instr,
                                                     input int unsigned lsb);
        logic [INSTR_W-1:0] sh;
        sh = instr >> lsb;
        return sh[REG_W-1:0];
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute-side signals seen by the hazard sequencer.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic [INSTR_W-1:0] IF_ID_instruction;
    logic [INSTR_W-1:0] ID_EX_instruction;
    logic               ID_EX_mem_read;
    logic               ID_EX_reg_write;
    logic               EX_MEM_reg_write;
    logic [REG_W-1:0]   EX_MEM_dst;
    logic               branch_taken;
    logic               mem_busy;
    logic               pc_write;
    logic               if_id_write;
    logic               if_id_flush;
    logic               id_ex_bubble;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;
    logic [1:0]         hz_state;
    logic [STALL_W-1:0] stall_cnt;

    // Pipeline side: supplies stage contents, consumes the strobes.
    modport master (
        output IF_ID_instruction, ID_EX_instruction, ID_EX_mem_read, ID_EX_reg_write,
               EX_MEM_reg_write, EX_MEM_dst, branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
               hz_state, stall_cnt
    );

    // Hazard sequencer side.
    modport slave (
        input  IF_ID_instruction, ID_EX_instruction, ID_EX_mem_read, ID_EX_reg_write,
               EX_MEM_reg_write, EX_MEM_dst, branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
               hz_state, stall_cnt
    );

endinterface

// File: rtl/fwd_sel.sv
// Operand-forwarding select for one source operand; EX result beats MEM result.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] ex_dst_i,
    input  logic             ex_reg_write_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] mem_dst_i,
    input  logic             mem_reg_write_i,
    output logic [1:0]       sel_o
);

    // A load's data is not ready in EX, so only ALU writers forward from EX.
    always_comb begin
        sel_o = FWD_REG;
        if (ex_reg_write_i && !ex_mem_read_i && (ex_dst_i == src_i)) begin
            sel_o = FWD_EX;
        end else if (mem_reg_write_i && (mem_dst_i == src_i)) begin
            sel_o = FWD_MEM;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, memory-busy holds, forwarding.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYC = 2
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);

    localparam logic [FCNT_W-1:0] FlushLoad = FCNT_W'(FLUSH_CYC - 1);
    localparam logic [STALL_W-1:0] StallMax = '1;

    hz_state_e          state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic [REG_W-1:0] ifid_src_a, ifid_src_b, idex_dst;
    logic             load_use;
    logic             pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [1:0]       fwd_a, fwd_b;

    assign ifid_src_a = instr_field(hz.IF_ID_instruction, SRC_A_LSB);
    assign ifid_src_b = instr_field(hz.IF_ID_instruction, SRC_B_LSB);
    assign idex_dst   = instr_field(hz.ID_EX_instruction, DST_LSB);

    assign load_use = hz.ID_EX_mem_read && hz.ID_EX_reg_write &&
                      ((idex_dst == ifid_src_a) || (idex_dst == ifid_src_b));

    fwd_sel u_fwd_a (
        .src_i          (ifid_src_a),
        .ex_dst_i       (idex_dst),
        .ex_reg_write_i (hz.ID_EX_reg_write),
        .ex_mem_read_i  (hz.ID_EX_mem_read),
        .mem_dst_i      (hz.EX_MEM_dst),
        .mem_reg_write_i(hz.EX_MEM_reg_write),
        .sel_o          (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src_i          (ifid_src_b),
        .ex_dst_i       (idex_dst),
        .ex_reg_write_i (hz.ID_EX_reg_write),
        .ex_mem_read_i  (hz.ID_EX_mem_read),
        .mem_dst_i      (hz.EX_MEM_dst),
        .mem_reg_write_i(hz.EX_MEM_reg_write),
        .sel_o          (fwd_b)
    );

    // Next state: branch > unfinished flush > mem_busy > load-use (from RUN only).
    always_comb begin
        state_d = StRun;
        fcnt_d  = fcnt_q;
        if (hz.branch_taken) begin
            state_d = StFlush;
            fcnt_d  = FlushLoad;
        end else if ((state_q == StFlush) && (fcnt_q != '0)) begin
            state_d = StFlush;
            fcnt_d  = fcnt_q - 1'b1;
        end else if (hz.mem_busy) begin
            state_d = StMemWait;
        end else if (load_use && (state_q == StRun)) begin
            state_d = StLdStall;
        end
    end

    // Saturating count of cycles spent outside RUN.
    always_comb begin
        stall_d = stall_q;
        if ((state_q != StRun) && (stall_q != StallMax)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            fcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            stall_q <= stall_d;
        end
    end

    // Moore strobes decoded from the current state.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        unique case (state_q)
            StRun: ;
            StLdStall: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
            StFlush: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            StMemWait: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end
            default: ;
        endcase
    end

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.fwd_a        = fwd_a;
    assign hz.fwd_b        = fwd_b;
    assign hz.hz_state     = state_q;
    assign hz.stall_cnt    = stall_q;

endmodule
